// File: rtl/cpu_pkg.sv
// Shared types and constants for the multicycle sequencer: opcode and state
// enums, instruction-word field positions and default widths.
package cpu_pkg;

    localparam int CPU_PC_W      = 4;
    localparam int CPU_DADDR_W   = 6;
    localparam int CPU_DATA_W    = 8;
    localparam int CPU_NREG      = 8;
    localparam int CPU_RA_W      = 3;
    localparam int CPU_IR_W      = 12;
    localparam int CPU_RETIRED_W = 8;

    // Instruction word field positions
    localparam int IR_OP_HI      = 11;
    localparam int IR_OP_LO      = 9;
    localparam int IR_RD_HI      = 8;
    localparam int IR_RD_LO      = 6;
    localparam int IR_LDADDR_HI  = 5;
    localparam int IR_LDADDR_LO  = 0;
    localparam int IR_STADDR_HI  = 8;
    localparam int IR_STADDR_LO  = 3;
    localparam int IR_RS1_HI     = 5;
    localparam int IR_RS1_LO     = 3;
    localparam int IR_RS2_HI     = 2;
    localparam int IR_RS2_LO     = 0;

    typedef enum logic [2:0] {
        OP_LD   = 3'd0,
        OP_ST   = 3'd1,
        OP_ADD  = 3'd2,
        OP_SUB  = 3'd3,
        OP_NOP4 = 3'd4,
        OP_NOP5 = 3'd5,
        OP_NOP6 = 3'd6,
        OP_HALT = 3'd7
    } cpu_op_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_DONE   = 3'd4
    } cpu_state_e;

    // Saturating increment for the retired-instruction counter
    function automatic logic [CPU_RETIRED_W-1:0] sat_inc(input logic [CPU_RETIRED_W-1:0] v);
        logic [CPU_RETIRED_W-1:0] r;
        if (v == {CPU_RETIRED_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + {{(CPU_RETIRED_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

endpackage

// File: rtl/cpu_regfile.sv
// Register file: NREG x DATA_W, two combinational read ports, one
// synchronous write port, all entries cleared by the asynchronous reset.
module cpu_regfile
    import cpu_pkg::*;
#(
    parameter int NREG   = CPU_NREG,
    parameter int DATA_W = CPU_DATA_W,
    parameter int AW     = CPU_RA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [AW-1:0]     i_raddr_a,
    output logic [DATA_W-1:0] o_rdata_a,
    input  logic [AW-1:0]     i_raddr_b,
    output logic [DATA_W-1:0] o_rdata_b
);

    logic [DATA_W-1:0] r_mem [NREG];

    // Register storage: cleared on reset, written on the clock edge when enabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a = r_mem[i_raddr_a];
    assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/cpu_seq_ctrl.sv
// Multicycle sequencer: FETCH/DECODE/EXEC over a 16x12 instruction memory
// and a 64x8 data memory, executing LD/ST/ADD with an internal register file.
// Optional feature macro: CPU_SUB_EN (op 011 becomes SUB; otherwise NOP).
module cpu_seq_ctrl
    import cpu_pkg::*;
#(
    parameter int PC_W    = CPU_PC_W,
    parameter int DADDR_W = CPU_DADDR_W,
    parameter int DATA_W  = CPU_DATA_W,
    parameter int NREG    = CPU_NREG
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic [PC_W-1:0]          imem_addr,
    input  logic [CPU_IR_W-1:0]      imem_rd_data,
    output logic                     dmem_we,
    output logic [DADDR_W-1:0]       dmem_addr,
    output logic [DATA_W-1:0]        dmem_wr_data,
    input  logic [DATA_W-1:0]        dmem_rd_data,
    output logic                     busy,
    output logic                     done,
    output logic [CPU_RETIRED_W-1:0] retired
);

    cpu_state_e                r_state;
    cpu_state_e                w_state_nxt;
    logic [PC_W-1:0]           r_pc;
    logic [CPU_IR_W-1:0]       r_ir;
    logic [DATA_W-1:0]         r_opa;
    logic [DATA_W-1:0]         r_opb;
    logic [CPU_RETIRED_W-1:0]  r_retired;

    cpu_op_e                   w_op;
    logic                      w_rf_we;
    logic [DATA_W-1:0]         w_rf_wdata;
    logic [DATA_W-1:0]         w_rf_rd_a;
    logic [DATA_W-1:0]         w_rf_rd_b;

    assign w_op = cpu_op_e'(r_ir[IR_OP_HI:IR_OP_LO]);

    cpu_regfile #(
        .NREG   (NREG),
        .DATA_W (DATA_W),
        .AW     (CPU_RA_W)
    ) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .i_we      (w_rf_we),
        .i_waddr   (r_ir[IR_RD_HI:IR_RD_LO]),
        .i_wdata   (w_rf_wdata),
        .i_raddr_a (r_ir[IR_RS1_HI:IR_RS1_LO]),
        .o_rdata_a (w_rf_rd_a),
        .i_raddr_b (r_ir[IR_RS2_HI:IR_RS2_LO]),
        .o_rdata_b (w_rf_rd_b)
    );

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic plus data-memory and register-file write strobes
    always_comb begin
        w_state_nxt  = r_state;
        dmem_we      = 1'b0;
        dmem_addr    = '0;
        dmem_wr_data = '0;
        w_rf_we      = 1'b0;
        w_rf_wdata   = '0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_state_nxt = ST_FETCH;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            ST_FETCH: begin
                w_state_nxt = ST_DECODE;
            end
            ST_DECODE: begin
                if (w_op == OP_HALT) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                // The last slot finishes the program rather than wrapping to PC 0
                if (r_pc == {PC_W{1'b1}}) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_FETCH;
                end
                case (w_op)
                    OP_LD: begin
                        dmem_addr  = r_ir[IR_LDADDR_HI:IR_LDADDR_LO];
                        w_rf_we    = 1'b1;
                        w_rf_wdata = dmem_rd_data;
                    end
                    OP_ST: begin
                        dmem_we      = 1'b1;
                        dmem_addr    = r_ir[IR_STADDR_HI:IR_STADDR_LO];
                        dmem_wr_data = r_opb;
                    end
                    OP_ADD: begin
                        w_rf_we    = 1'b1;
                        w_rf_wdata = r_opa + r_opb;
                    end
`ifdef CPU_SUB_EN
                    OP_SUB: begin
                        w_rf_we    = 1'b1;
                        w_rf_wdata = r_opa - r_opb;
                    end
`endif
                    default: begin
                        w_rf_we = 1'b0;
                    end
                endcase
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // PC, instruction register, operand latches and retired counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc      <= '0;
            r_ir      <= '0;
            r_opa     <= '0;
            r_opb     <= '0;
            r_retired <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_pc      <= '0;
                        r_retired <= '0;
                    end
                end
                ST_FETCH: begin
                    r_ir <= imem_rd_data;
                end
                ST_DECODE: begin
                    r_opa <= w_rf_rd_a;
                    r_opb <= w_rf_rd_b;
                end
                ST_EXEC: begin
                    r_pc      <= r_pc + {{(PC_W-1){1'b0}}, 1'b1};
                    r_retired <= sat_inc(r_retired);
                end
                default: begin
                    r_pc <= r_pc;
                end
            endcase
        end
    end

    assign imem_addr = r_pc;
    assign busy      = (r_state == ST_FETCH) || (r_state == ST_DECODE) || (r_state == ST_EXEC);
    assign done      = (r_state == ST_DONE);
    assign retired   = r_retired;

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Directed testbench for cpu_seq_ctrl with behavioural imem/dmem models.
module tb_cpu_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  imem_addr;
    logic [11:0] imem_rd_data;
    logic        dmem_we;
    logic [5:0]  dmem_addr;
    logic [7:0]  dmem_wr_data;
    logic [7:0]  dmem_rd_data;
    logic        busy;
    logic        done;
    logic [7:0]  retired;

    logic [11:0] imem [16];
    logic [7:0]  dmem [64];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign imem_rd_data = imem[imem_addr];
    assign dmem_rd_data = dmem[dmem_addr];

    // Data memory write port
    always @(posedge clk) begin
        if (dmem_we) dmem[dmem_addr] <= dmem_wr_data;
    end

    cpu_seq_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .imem_addr    (imem_addr),
        .imem_rd_data (imem_rd_data),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_wr_data (dmem_wr_data),
        .dmem_rd_data (dmem_rd_data),
        .busy         (busy),
        .done         (done),
        .retired      (retired)
    );

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] enc_ld(input int rd, input int addr);
        logic [2:0] r; logic [5:0] a;
        r = rd[2:0]; a = addr[5:0];
        return {3'b000, r, a};
    endfunction
    function automatic logic [11:0] enc_st(input int addr, input int rs);
        logic [2:0] r; logic [5:0] a;
        r = rs[2:0]; a = addr[5:0];
        return {3'b001, a, r};
    endfunction
    function automatic logic [11:0] enc_alu(input logic [2:0] op, input int rd, input int a, input int b);
        logic [2:0] d, x, y;
        d = rd[2:0]; x = a[2:0]; y = b[2:0];
        return {op, d, x, y};
    endfunction

    localparam logic [11:0] NOP  = 12'h800;
    localparam logic [11:0] HALT = 12'hE00;

    task automatic clear_imem();
        for (int i = 0; i < 16; i++) imem[i] = HALT;
    endtask

    // Start the program, optionally pulse start again at cycle pulse_at, wait for done
    task automatic run_prog(input int pulse_at, output int lat, output int busy_n,
                            output int we_n, output int zero_fetch);
        lat = 0; busy_n = 0; we_n = 0; zero_fetch = 0;
        @(posedge clk); #1 start = 1'b1;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk); #1;
            start = (c == pulse_at);
            lat = c;
            if (busy) busy_n++;
            if (dmem_we) we_n++;
            if (busy && imem_addr == 4'd0 && c > 3) zero_fetch++;
            if (done) break;
        end
        start = 1'b0;
        if (!done) check_vec("done_timeout", {31'd0, done}, 32'd1);
    endtask

    int lat, bsy, wen, zf;

    initial begin
        rst = 1'b1; start = 1'b0;
        clear_imem();
        for (int i = 0; i < 64; i++) dmem[i] = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check_vec("rst_busy", {31'd0, busy}, 32'd0);
        check_vec("rst_done", {31'd0, done}, 32'd0);
        check_vec("rst_retired", {24'd0, retired}, 32'd0);
        check_vec("rst_imem_addr", {28'd0, imem_addr}, 32'd0);
        check_vec("rst_dmem_we", {31'd0, dmem_we}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check_vec("idle_busy", {31'd0, busy}, 32'd0);

        // Test 1: default program
        dmem[0] = 8'h01; dmem[1] = 8'h01;
        imem[0]  = enc_ld(0, 0);
        imem[1]  = enc_ld(1, 1);
        imem[2]  = enc_alu(3'b010, 2, 0, 1);
        imem[3]  = enc_alu(3'b010, 3, 1, 2);
        imem[4]  = enc_alu(3'b010, 4, 2, 3);
        imem[5]  = enc_st(2, 2);
        imem[6]  = enc_st(3, 3);
        imem[7]  = enc_st(4, 4);
        for (int i = 8; i < 13; i++) imem[i] = enc_ld(5, 2);
        imem[13] = HALT;
        run_prog(0, lat, bsy, wen, zf);
        check_vec("t1_dmem2", {24'd0, dmem[2]}, 32'h02);
        check_vec("t1_dmem3", {24'd0, dmem[3]}, 32'h03);
        check_vec("t1_dmem4", {24'd0, dmem[4]}, 32'h05);
        check_vec("t1_done_lat", lat, 32'd42);
        check_vec("t1_retired", {24'd0, retired}, 32'd13);
        check_vec("t1_we_cycles", wen, 32'd3);
        @(posedge clk); #1;
        check_vec("t1_done_held", {31'd0, done}, 32'd1);

        // Test 2: add wraps, carry dropped
        clear_imem();
        dmem[6] = 8'hFF; dmem[7] = 8'h02; dmem[5] = 8'h00;
        imem[0] = enc_ld(0, 6);
        imem[1] = enc_ld(1, 7);
        imem[2] = enc_alu(3'b010, 2, 0, 1);
        imem[3] = enc_st(5, 2);
        run_prog(0, lat, bsy, wen, zf);
        check_vec("t2_wrap", {24'd0, dmem[5]}, 32'h01);
        check_vec("t2_retired", {24'd0, retired}, 32'd4);

        // Test 3: 16 NOPs, no HALT, ends without wrapping to PC 0
        for (int i = 0; i < 16; i++) imem[i] = NOP;
        run_prog(0, lat, bsy, wen, zf);
        check_vec("t3_busy_cycles", bsy, 32'd48);
        check_vec("t3_done_lat", lat, 32'd49);
        check_vec("t3_no_refetch0", zf, 32'd0);
        check_vec("t3_retired", {24'd0, retired}, 32'd16);
        check_vec("t3_no_we", wen, 32'd0);

        // Test 4: reset during EXEC of ST
        clear_imem();
        dmem[14] = 8'h5A; dmem[10] = 8'hAA; dmem[11] = 8'h33;
        imem[0] = enc_ld(0, 14);
        imem[1] = enc_st(10, 0);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (dmem_we) break;
            @(posedge clk); #1;
        end
        check_vec("t4_st_reached", {31'd0, dmem_we}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_vec("t4_we_drop", {31'd0, dmem_we}, 32'd0);
        check_vec("t4_busy", {31'd0, busy}, 32'd0);
        check_vec("t4_retired", {24'd0, retired}, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        check_vec("t4_byte_kept", {24'd0, dmem[10]}, 32'hAA);
        clear_imem();
        imem[0] = enc_st(11, 0);
        run_prog(0, lat, bsy, wen, zf);
        check_vec("t4_regs_cleared", {24'd0, dmem[11]}, 32'h00);

        // Test 5: start while busy ignored; start in DONE reruns
        clear_imem();
        for (int i = 0; i < 4; i++) imem[i] = NOP;
        run_prog(5, lat, bsy, wen, zf);
        check_vec("t5_busy_start_lat", lat, 32'd15);
        check_vec("t5_retired", {24'd0, retired}, 32'd4);
        run_prog(0, lat, bsy, wen, zf);
        check_vec("t5_rerun_lat", lat, 32'd15);
        check_vec("t5_rerun_retired", {24'd0, retired}, 32'd4);

        // Test 6: op 011
        clear_imem();
        dmem[13] = 8'h77; dmem[8] = 8'h03; dmem[9] = 8'h05; dmem[12] = 8'h00;
        imem[0] = enc_ld(3, 13);
        imem[1] = enc_ld(1, 8);
        imem[2] = enc_ld(2, 9);
        imem[3] = enc_alu(3'b011, 3, 1, 2);
        imem[4] = enc_st(12, 3);
        run_prog(0, lat, bsy, wen, zf);
`ifdef CPU_SUB_EN
        check_vec("t6_sub", {24'd0, dmem[12]}, 32'hFE);
`else
        check_vec("t6_nop", {24'd0, dmem[12]}, 32'h77);
`endif
        check_vec("t6_retired", {24'd0, retired}, 32'd5);
        check_vec("t6_lat", lat, 32'd18);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
